// File: rtl/instr_stream_arbiter_if.sv
// rtl/instr_stream_arbiter_if.sv - host-side and scheduler-side stream bundle for instr_stream_arbiter
interface instr_stream_arbiter_if #(
    parameter int NUM_SRC       = 2,
    parameter int INSTR_WIDTH   = 128,
    parameter int WDATA_WIDTH   = 512,
    parameter int WR_FIFO_DEPTH = 8
);
    // Per-source host instruction streams, source i at slice i
    logic [NUM_SRC*INSTR_WIDTH-1:0] s_instr_tdata;
    logic [NUM_SRC-1:0]             s_instr_tvalid;
    logic [NUM_SRC-1:0]             s_instr_tlast;
    logic [NUM_SRC-1:0]             s_instr_tready;

    // Per-source host write-data streams
    logic [NUM_SRC*WDATA_WIDTH-1:0] s_wdata_tdata;
    logic [NUM_SRC-1:0]             s_wdata_tvalid;
    logic [NUM_SRC-1:0]             s_wdata_tready;

    // Merged instruction stream towards the scheduler
    logic [INSTR_WIDTH-1:0]         m_instr_tdata;
    logic                           m_instr_tvalid;
    logic                           m_instr_tlast;
    logic                           m_instr_tready;

    // Merged write-data stream towards the scheduler
    logic [WDATA_WIDTH-1:0]         m_wdata_tdata;
    logic                           m_wdata_tvalid;
    logic                           m_wdata_tready;

    // Owner-FIFO occupancy
    logic [$clog2(WR_FIFO_DEPTH):0] wr_pending;

    // Arbiter side
    modport slave (
        input  s_instr_tdata, s_instr_tvalid, s_instr_tlast,
        output s_instr_tready,
        input  s_wdata_tdata, s_wdata_tvalid,
        output s_wdata_tready,
        output m_instr_tdata, m_instr_tvalid, m_instr_tlast,
        input  m_instr_tready,
        output m_wdata_tdata, m_wdata_tvalid,
        input  m_wdata_tready,
        output wr_pending
    );

    // Environment side (host channels plus scheduler)
    modport master (
        output s_instr_tdata, s_instr_tvalid, s_instr_tlast,
        input  s_instr_tready,
        output s_wdata_tdata, s_wdata_tvalid,
        input  s_wdata_tready,
        input  m_instr_tdata, m_instr_tvalid, m_instr_tlast,
        output m_instr_tready,
        input  m_wdata_tdata, m_wdata_tvalid,
        output m_wdata_tready,
        input  wr_pending
    );
endinterface

// File: rtl/instr_stream_arbiter.sv
// rtl/instr_stream_arbiter.sv - burst-locked round-robin instruction arbiter with in-order wdata owner FIFO (ARB_STRICT_PRIORITY_EN selects fixed priority)
module instr_stream_arbiter #(
    parameter int NUM_SRC       = 2,
    parameter int INSTR_WIDTH   = 128,
    parameter int WDATA_WIDTH   = 512,
    parameter int WR_FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_stream_arbiter_if.slave  bus
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(WR_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;

    // Owner FIFO: one entry per forwarded WR-bearing beat, holding its source
    logic [SRC_W-1:0]   fifo_q [WR_FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic [INSTR_WIDTH-1:0] instr_slice [NUM_SRC];
    logic [WDATA_WIDTH-1:0] wdata_slice [NUM_SRC];

    logic [INSTR_WIDTH-1:0] g_instr;
    logic                   g_valid;
    logic                   g_last;
    logic                   wr_beat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   stall;
    logic                   push;
    logic                   pop;
    logic [SRC_W-1:0]       owner;

    logic                   pick_valid;
    logic [SRC_W-1:0]       pick_idx;

    logic [NUM_SRC-1:0]     s_instr_tready_c;
    logic [NUM_SRC-1:0]     s_wdata_tready_c;
    logic [INSTR_WIDTH-1:0] m_instr_tdata_c;
    logic                   m_instr_tvalid_c;
    logic                   m_instr_tlast_c;
    logic [WDATA_WIDTH-1:0] m_wdata_tdata_c;
    logic                   m_wdata_tvalid_c;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
        assign instr_slice[i] = bus.s_instr_tdata[i*INSTR_WIDTH +: INSTR_WIDTH];
        assign wdata_slice[i] = bus.s_wdata_tdata[i*WDATA_WIDTH +: WDATA_WIDTH];
    end

    assign g_instr = instr_slice[grant_q];
    assign g_valid = bus.s_instr_tvalid[grant_q];
    assign g_last  = bus.s_instr_tlast[grant_q];

    // Any of the four 32-bit commands carrying opcode 4 needs a wdata beat
    assign wr_beat = (g_instr[2:0]   == 3'd4) || (g_instr[34:32] == 3'd4) ||
                     (g_instr[66:64] == 3'd4) || (g_instr[98:96] == 3'd4);

    assign fifo_full  = (count_q == CNT_W'(WR_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign owner      = fifo_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a full FIFO needs for the push
    assign pop   = !fifo_empty && bus.s_wdata_tvalid[owner] && bus.m_wdata_tready;
    assign stall = wr_beat && fifo_full && !pop;

    // Pick the next source to grant: round-robin after last_grant, or lowest index
    always_comb begin
        int c;
        pick_valid = 1'b0;
        pick_idx   = '0;
        c          = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
`ifdef ARB_STRICT_PRIORITY_EN
            c = k;
`else
            c = (int'(last_grant_q) + 1 + k) % NUM_SRC;
`endif
            if (!pick_valid && bus.s_instr_tvalid[c]) begin
                pick_valid = 1'b1;
                pick_idx   = SRC_W'(c);
            end
        end
    end

    // Arbitration state, current grant and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state and instruction-path outputs; the grant is held until tlast
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_grant_d     = last_grant_q;
        push             = 1'b0;
        s_instr_tready_c = '0;
        m_instr_tdata_c  = '0;
        m_instr_tvalid_c = 1'b0;
        m_instr_tlast_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                m_instr_tdata_c           = g_instr;
                m_instr_tlast_c           = g_last;
                m_instr_tvalid_c          = g_valid && !stall;
                s_instr_tready_c[grant_q] = bus.m_instr_tready && !stall;
                if (g_valid && !stall && bus.m_instr_tready) begin
                    push = wr_beat;
                    if (g_last) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write-data path: only the source at the FIFO head may pass a beat
    always_comb begin
        s_wdata_tready_c = '0;
        m_wdata_tdata_c  = '0;
        m_wdata_tvalid_c = 1'b0;
        if (!fifo_empty) begin
            m_wdata_tdata_c         = wdata_slice[owner];
            m_wdata_tvalid_c        = bus.s_wdata_tvalid[owner];
            s_wdata_tready_c[owner] = bus.m_wdata_tready;
        end
    end

    // Owner FIFO pointers and occupancy; contents are dropped on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Owner FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= grant_q;
        end
    end

    assign bus.s_instr_tready = s_instr_tready_c;
    assign bus.s_wdata_tready = s_wdata_tready_c;
    assign bus.m_instr_tdata  = m_instr_tdata_c;
    assign bus.m_instr_tvalid = m_instr_tvalid_c;
    assign bus.m_instr_tlast  = m_instr_tlast_c;
    assign bus.m_wdata_tdata  = m_wdata_tdata_c;
    assign bus.m_wdata_tvalid = m_wdata_tvalid_c;
    assign bus.wr_pending     = count_q;

endmodule
